sram_access_arbiter: RTL

- Owns the single SRAM_controller port and shares it among four requesters: UART receive, Milestone 2, Milestone 1 and VGA.
- Replaces the ad-hoc top-level state-based address/data/we_n mux with a request/grant handshake.
- Inserts a drain gap on every ownership change so in-flight reads return to the correct owner.
- VGA is the background owner: it holds the SRAM whenever no other requester is pending.

---
 rtl/sram_access_arbiter_pkg.sv | 24 ++
 rtl/sram_access_arbiter_if.sv | 33 +++
 rtl/sram_arb_priority_enc.sv | 29 ++
 rtl/sram_access_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sram_access_arbiter_pkg.sv
// Shared types and constants for the SRAM access arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        S_ARB_VGA   = 2'd0,
        S_ARB_DRAIN = 2'd1,
        S_ARB_GRANT = 2'd2
    } arb_state_type;

    localparam logic [1:0] REQ_UART = 2'd0;
    localparam logic [1:0] REQ_M2   = 2'd1;
    localparam logic [1:0] REQ_M1   = 2'd2;
    localparam logic [1:0] REQ_VGA  = 2'd3;
    localparam int         NUM_REQ  = 4;

    localparam logic [3:0] GRANT_VGA  = 4'b1000;
    localparam logic [3:0] GRANT_NONE = 4'b0000;

    // One-hot grant vector for a requester index.
    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Request/grant bundle between the SRAM users and the arbiter.
interface sram_access_arbiter_if;

    logic [3:0]        req_i;
    logic [3:0][17:0]  req_address_i;
    logic [3:0][15:0]  req_write_data_i;
    logic [3:0]        req_we_n_i;

    logic [3:0]        grant_o;
    logic [1:0]        owner_o;
    logic              VGA_enable_o;
    logic              busy_o;
    logic              timeout_o;

    logic [17:0]       SRAM_address_o;
    logic [15:0]       SRAM_write_data_o;
    logic              SRAM_we_n_o;

    // Requester side: drives requests and per-requester bus values.
    modport master (
        output req_i, req_address_i, req_write_data_i, req_we_n_i,
        input  grant_o, owner_o, VGA_enable_o, busy_o, timeout_o,
        input  SRAM_address_o, SRAM_write_data_o, SRAM_we_n_o
    );

    // Arbiter side.
    modport slave (
        input  req_i, req_address_i, req_write_data_i, req_we_n_i,
        output grant_o, owner_o, VGA_enable_o, busy_o, timeout_o,
        output SRAM_address_o, SRAM_write_data_o, SRAM_we_n_o
    );

endinterface

// File: rtl/sram_arb_priority_enc.sv
// Fixed-priority encoder: lowest set bit wins (UART > M2 > M1).
module sram_arb_priority_enc
    import sram_arb_pkg::*;
(
    input  logic [2:0] req_vec_s,
    output logic       hit_s,
    output logic [1:0] idx_s
);

    // Pick the lowest pending requester index.
    always_comb begin
        hit_s = 1'b0;
        idx_s = REQ_UART;
        if (req_vec_s[0]) begin
            hit_s = 1'b1;
            idx_s = REQ_UART;
        end else if (req_vec_s[1]) begin
            hit_s = 1'b1;
            idx_s = REQ_M2;
        end else if (req_vec_s[2]) begin
            hit_s = 1'b1;
            idx_s = REQ_M1;
        end else begin
            hit_s = 1'b0;
            idx_s = REQ_UART;
        end
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares the single SRAM controller port among UART, M2, M1 and VGA.
// VGA owns the SRAM by default; every ownership change passes through a
// drain gap of READ_LATENCY cycles so in-flight reads land with their owner.
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int          READ_LATENCY = 3,
    parameter logic [25:0] HOLD_TIMEOUT = 26'd50000000
)(
    input  logic CLOCK_50_I,
    input  logic resetn,
    sram_access_arbiter_if.slave bus
);

    localparam int          DRAIN_W    = (READ_LATENCY + 1 > 2) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(READ_LATENCY - 1);
    localparam logic [25:0] HOLD_LAST  = HOLD_TIMEOUT - 26'd1;

    arb_state_type        state_r, state_nxt_s;
    logic [3:0]           grant_r, grant_nxt_s;
    logic [1:0]           owner_r, owner_nxt_s;
    logic [DRAIN_W-1:0]   drain_cnt_r, drain_nxt_s;
    logic [25:0]          hold_cnt_r, hold_nxt_s;
    logic                 busy_r, timeout_r, timeout_nxt_s;

    logic                 pend_hit_s;
    logic [1:0]           pend_idx_s;

    logic [17:0]          sram_address_s;
    logic [15:0]          sram_write_data_s;
    logic                 sram_we_n_s;

    sram_arb_priority_enc u_prio (
        .req_vec_s (bus.req_i[2:0]),
        .hit_s     (pend_hit_s),
        .idx_s     (pend_idx_s)
    );

    // Next-state, next-grant and drain counter logic.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        owner_nxt_s = owner_r;
        drain_nxt_s = drain_cnt_r;
        case (state_r)
            S_ARB_VGA: begin
                if (|bus.req_i[2:0]) begin
                    state_nxt_s = S_ARB_DRAIN;
                    grant_nxt_s = GRANT_NONE;
                    drain_nxt_s = '0;
                end else begin
                    grant_nxt_s = GRANT_VGA;
                    owner_nxt_s = REQ_VGA;
                end
            end
            S_ARB_DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) begin
                    drain_nxt_s = '0;
                    if (pend_hit_s) begin
                        state_nxt_s = S_ARB_GRANT;
                        grant_nxt_s = idx_to_onehot(pend_idx_s);
                        owner_nxt_s = pend_idx_s;
                    end else begin
                        state_nxt_s = S_ARB_VGA;
                        grant_nxt_s = GRANT_VGA;
                        owner_nxt_s = REQ_VGA;
                    end
                end else begin
                    drain_nxt_s = drain_cnt_r + DRAIN_W'(1);
                end
            end
            S_ARB_GRANT: begin
                if (!bus.req_i[owner_r]) begin
                    state_nxt_s = S_ARB_DRAIN;
                    grant_nxt_s = GRANT_NONE;
                    drain_nxt_s = '0;
                end else begin
                    grant_nxt_s = grant_r;
                end
            end
            default: begin
                state_nxt_s = S_ARB_VGA;
                grant_nxt_s = GRANT_VGA;
                owner_nxt_s = REQ_VGA;
                drain_nxt_s = '0;
            end
        endcase
    end

    // Hold counter: restarts on each grant edge, saturates at HOLD_LAST.
    // The timeout flag is raised in the same cycle the counter reaches HOLD_LAST.
    always_comb begin
        hold_nxt_s    = hold_cnt_r;
        timeout_nxt_s = timeout_r;
        if ((state_nxt_s == S_ARB_GRANT) && (state_r != S_ARB_GRANT)) begin
            hold_nxt_s = 26'd0;
        end else if ((state_r == S_ARB_GRANT) && (hold_cnt_r != HOLD_LAST)) begin
            hold_nxt_s = hold_cnt_r + 26'd1;
        end else begin
            hold_nxt_s = hold_cnt_r;
        end
        if ((state_nxt_s == S_ARB_GRANT) && (hold_nxt_s == HOLD_LAST)) begin
            timeout_nxt_s = 1'b1;
        end else begin
            timeout_nxt_s = timeout_r;
        end
    end

    // State and registered output flops.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            state_r     <= S_ARB_VGA;
            grant_r     <= GRANT_VGA;
            owner_r     <= REQ_VGA;
            drain_cnt_r <= '0;
            hold_cnt_r  <= 26'd0;
            busy_r      <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            grant_r     <= grant_nxt_s;
            owner_r     <= owner_nxt_s;
            drain_cnt_r <= drain_nxt_s;
            hold_cnt_r  <= hold_nxt_s;
            busy_r      <= (state_nxt_s != S_ARB_VGA);
            timeout_r   <= timeout_nxt_s;
        end
    end

    // SRAM port mux: owner's values while granted, idle read of address 0
    // during drain, and write forced off while reset is held.
    always_comb begin
        sram_address_s    = 18'd0;
        sram_write_data_s = 16'd0;
        sram_we_n_s       = 1'b1;
        if (!resetn) begin
            sram_we_n_s = 1'b1;
        end else if (grant_r != GRANT_NONE) begin
            sram_address_s    = bus.req_address_i[owner_r];
            sram_write_data_s = bus.req_write_data_i[owner_r];
            sram_we_n_s       = bus.req_we_n_i[owner_r];
        end else begin
            sram_we_n_s = 1'b1;
        end
    end

    assign bus.grant_o           = grant_r;
    assign bus.owner_o           = owner_r;
    assign bus.VGA_enable_o      = grant_r[REQ_VGA];
    assign bus.busy_o            = busy_r;
    assign bus.timeout_o         = timeout_r;
    assign bus.SRAM_address_o    = sram_address_s;
    assign bus.SRAM_write_data_o = sram_write_data_s;
    assign bus.SRAM_we_n_o       = sram_we_n_s;

endmodule
